// File: rtl/serial_demux8_pkg.sv
// ---------------------------------------------------------------------------
// serial_demux_pkg
// Shared definitions for the serial_demux8 receiver: default word width and
// the receive FSM state encoding.
// ---------------------------------------------------------------------------
package serial_demux_pkg;

    localparam int DEF_WIDTH = 8;

    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } state_t;

endpackage

// File: rtl/serial_demux8_if.sv
// ---------------------------------------------------------------------------
// serial_demux8_if
// Bundles the serial input side and the parallel output side of the
// serial_demux8 receiver.
//   din, din_valid, frame : serial bit, its qualifier, start-of-word marker
//   dout, dout_valid      : last complete word (dout[0] = first bit) + strobe
//   sel, busy, frame_err  : next slot, partial-word flag, resync pulse
// master: the serial transmitter side; slave: the receiver.
// ---------------------------------------------------------------------------
interface serial_demux8_if
    import serial_demux_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);
    localparam int SEL_W = $clog2(WIDTH);

    logic             din;
    logic             din_valid;
    logic             frame;
    logic [0:WIDTH-1] dout;
    logic             dout_valid;
    logic [SEL_W-1:0] sel;
    logic             busy;
    logic             frame_err;

    modport master (
        output din, din_valid, frame,
        input  dout, dout_valid, sel, busy, frame_err
    );

    modport slave (
        input  din, din_valid, frame,
        output dout, dout_valid, sel, busy, frame_err
    );

endinterface

// File: rtl/serial_demux8_sel_decoder.sv
// ---------------------------------------------------------------------------
// sel_decoder
// Combinational one-hot write-enable decoder: the 1:WIDTH demultiplexer.
//   en  : global enable (an accepted data bit)
//   sel : slot index
//   we  : we[i] high when en is high and sel == i
// ---------------------------------------------------------------------------
module sel_decoder
    import serial_demux_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic                     en,
    input  logic [$clog2(WIDTH)-1:0] sel,
    output logic [0:WIDTH-1]         we
);
    localparam int SEL_W = $clog2(WIDTH);

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_we
            assign we[gi] = en && (sel == SEL_W'(gi));
        end
    endgenerate

endmodule

// File: rtl/serial_demux8.sv
// ---------------------------------------------------------------------------
// serial_demux8
// Serial-to-parallel receiver. Accepted bits are steered into a shadow
// register slot selected by a slot counter; a completed word is copied to
// dout with a one-cycle dout_valid strobe. A frame bit during a partial word
// restarts reception and pulses frame_err.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : serial_demux8_if.slave (see interface header for signals)
// ---------------------------------------------------------------------------
module serial_demux8
    import serial_demux_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic          clk,
    input  logic          rst_n,
    serial_demux8_if.slave bus
);
    localparam int SEL_W = $clog2(WIDTH);
    localparam logic [SEL_W-1:0] LAST_SLOT = SEL_W'(WIDTH - 1);

    state_t           state_reg, state_next;
    logic [SEL_W-1:0] sel_reg, sel_next;
    logic [0:WIDTH-1] shadow_reg, shadow_next;
    logic [0:WIDTH-1] dout_reg, dout_next;
    logic             dout_valid_reg, dout_valid_next;
    logic             frame_err_reg, frame_err_next;

    logic [0:WIDTH-1] we;
    logic [0:WIDTH-1] word_in;
    logic             data_bit;

    // Only non-frame bits in RECV go through the demux; frame bits always
    // restart the word at slot 0 with the rest of the shadow cleared.
    assign data_bit = bus.din_valid && !bus.frame && (state_reg == RECV);

    sel_decoder #(
        .WIDTH (WIDTH)
    ) u_sel_decoder (
        .en  (data_bit),
        .sel (sel_reg),
        .we  (we)
    );

    // Shadow contents with the current bit merged into the addressed slot;
    // on the last slot this is exactly the completed word.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_merge
            assign word_in[gi] = we[gi] ? bus.din : shadow_reg[gi];
        end
    endgenerate

    always_comb begin
        state_next      = state_reg;
        sel_next        = sel_reg;
        shadow_next     = shadow_reg;
        dout_next       = dout_reg;
        dout_valid_next = 1'b0;
        frame_err_next  = 1'b0;

        if (bus.din_valid && bus.frame) begin
            // New word (from IDLE) or resync (from RECV): same restart.
            shadow_next    = '0;
            shadow_next[0] = bus.din;
            sel_next       = SEL_W'(1);
            state_next     = RECV;
            frame_err_next = (state_reg == RECV);
        end else if (data_bit) begin
            shadow_next = word_in;
            if (sel_reg == LAST_SLOT) begin
                dout_next       = word_in;
                dout_valid_next = 1'b1;
                sel_next        = '0;
                state_next      = IDLE;
            end else begin
                sel_next = sel_reg + SEL_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            sel_reg        <= '0;
            shadow_reg     <= '0;
            dout_reg       <= '0;
            dout_valid_reg <= 1'b0;
            frame_err_reg  <= 1'b0;
        end else begin
            state_reg      <= state_next;
            sel_reg        <= sel_next;
            shadow_reg     <= shadow_next;
            dout_reg       <= dout_next;
            dout_valid_reg <= dout_valid_next;
            frame_err_reg  <= frame_err_next;
        end
    end

    assign bus.dout       = dout_reg;
    assign bus.dout_valid = dout_valid_reg;
    assign bus.sel        = sel_reg;
    assign bus.busy       = (state_reg == RECV);
    assign bus.frame_err  = frame_err_reg;

endmodule

// File: tb/tb_serial_demux8.sv
`timescale 1ns/100ps
module tb_serial_demux8;
    import serial_demux_pkg::*;

    logic clk;
    logic rst_n;

    int n_checks;
    int n_errors;
    int cyc;
    int dv_count;
    int dv_prev_cyc;
    int dv_last_cyc;

    serial_demux8_if #(.WIDTH(8)) bus ();

    serial_demux8 #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counts dout_valid pulses and remembers when the last two occurred.
    always @(posedge clk) begin
        #2;
        cyc = cyc + 1;
        if (bus.dout_valid === 1'b1) begin
            dv_count    = dv_count + 1;
            dv_prev_cyc = dv_last_cyc;
            dv_last_cyc = cyc;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive one cycle of inputs (tb always sits at a negedge) and let one
    // rising edge pass; returns at the following negedge.
    task automatic cycle(input logic v, input logic f, input logic d);
        bus.din_valid = v;
        bus.frame     = f;
        bus.din       = d;
        @(negedge clk);
    endtask

    // Sends a full word starting with a frame bit; optionally inserts an
    // idle gap of gap_len cycles after bit index gap_after.
    task automatic send_word(input logic [0:7] w, input int gap_after, input int gap_len,
                             input logic [7:0] prev_dout);
        int dv_start;
        dv_start = dv_count;
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, (i == 0), w[i]);
            if (i < 7) begin
                check_val("bit_sel", bus.sel, i + 1);
                check_val("bit_busy", bus.busy, 1);
                check_val("bit_dv", bus.dout_valid, 0);
                check_val("bit_ferr", bus.frame_err, 0);
                check_val("bit_dout_hold", bus.dout, prev_dout);
            end
            if (i == gap_after) begin
                for (int g = 0; g < gap_len; g++) begin
                    cycle(1'b0, 1'b1, ~w[i]);
                    check_val("gap_sel", bus.sel, i + 1);
                    check_val("gap_busy", bus.busy, 1);
                    check_val("gap_dv", bus.dout_valid, 0);
                end
            end
        end
        check_val("word_dout", bus.dout, w);
        check_val("word_dv", bus.dout_valid, 1);
        check_val("word_busy", bus.busy, 0);
        check_val("word_sel", bus.sel, 0);
        check_val("word_dv_count", dv_count - dv_start, 1);
        $display("word sent %02h received %02h", w, bus.dout);
    endtask

    initial begin
        n_checks = 0; n_errors = 0; cyc = 0;
        dv_count = 0; dv_prev_cyc = 0; dv_last_cyc = 0;
        rst_n = 1'b0;
        bus.din = 1'b0; bus.din_valid = 1'b0; bus.frame = 1'b0;
        @(negedge clk);

        // 1: reset held while inputs toggle
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, i[0], ~i[1]);
            check_val("rst_dout", bus.dout, 0);
            check_val("rst_dv", bus.dout_valid, 0);
            check_val("rst_sel", bus.sel, 0);
            check_val("rst_busy", bus.busy, 0);
            check_val("rst_ferr", bus.frame_err, 0);
        end
        rst_n = 1'b1;
        cycle(1'b0, 1'b0, 1'b0);
        // non-frame bit in IDLE is ignored
        cycle(1'b1, 1'b0, 1'b1);
        check_val("idle_ignore_busy", bus.busy, 0);
        check_val("idle_ignore_sel", bus.sel, 0);

        // 2: contiguous word
        send_word(8'b10110010, -1, 0, 8'h00);
        cycle(1'b0, 1'b0, 1'b0);
        check_val("w2_dv_low", bus.dout_valid, 0);
        check_val("w2_dout_hold", bus.dout, 8'hB2);

        // 3: same word with a 3-cycle gap after bit3
        send_word(8'b10110010, 3, 3, 8'hB2);
        cycle(1'b0, 1'b0, 1'b0);

        // 4: resync after a partial word of 5 bits
        begin
            int dv0;
            dv0 = dv_count;
            cycle(1'b1, 1'b1, 1'b0);
            for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 1'b0);
            check_val("rs_sel_before", bus.sel, 5);
            cycle(1'b1, 1'b1, 1'b1);
            check_val("rs_ferr", bus.frame_err, 1);
            check_val("rs_sel", bus.sel, 1);
            check_val("rs_busy", bus.busy, 1);
            check_val("rs_dv", bus.dout_valid, 0);
            check_val("rs_dout_hold", bus.dout, 8'hB2);
            for (int i = 1; i < 8; i++) begin
                cycle(1'b1, 1'b0, 1'b1);
                if (i == 1) check_val("rs_ferr_pulse", bus.frame_err, 0);
            end
            check_val("rs_dout", bus.dout, 8'hFF);
            check_val("rs_dv_end", bus.dout_valid, 1);
            check_val("rs_dv_count", dv_count - dv0, 1);
            $display("resync word received %02h", bus.dout);
        end

        // 5: back-to-back words
        cycle(1'b0, 1'b0, 1'b0);
        send_word(8'hA5, -1, 0, 8'hFF);
        send_word(8'h3C, -1, 0, 8'hA5);
        check_val("b2b_spacing", dv_last_cyc - dv_prev_cyc, 8);
        cycle(1'b0, 1'b0, 1'b0);
        check_val("b2b_dv_low", bus.dout_valid, 0);

        // 6: asynchronous reset mid-word
        begin
            int dv0;
            dv0 = dv_count;
            for (int i = 0; i < 5; i++) cycle(1'b1, (i == 0), 1'b1);
            check_val("mr_sel_before", bus.sel, 5);
            #2 rst_n = 1'b0;
            #1;
            check_val("mr_dout", bus.dout, 0);
            check_val("mr_sel", bus.sel, 0);
            check_val("mr_busy", bus.busy, 0);
            check_val("mr_dv", bus.dout_valid, 0);
            check_val("mr_ferr", bus.frame_err, 0);
            @(negedge clk);
            rst_n = 1'b1;
            cycle(1'b0, 1'b0, 1'b0);
            check_val("mr_no_dv", dv_count - dv0, 0);
            send_word(8'h81, -1, 0, 8'h00);
            check_val("mr_dv_total", dv_count - dv0, 1);
        end

        cycle(1'b0, 1'b0, 1'b0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // Hard bound so the run always terminates.
    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
